aes128_round_ctrl: RTL and testbench

Iterative AES-128 encryption engine controller. It accepts one plaintext/key pair over a valid/ready handshake and runs one full round per clock through the existing combinational round functions: sub_bytes, shift_rows, mix_columns and add_round_key. It generates round keys on the fly and returns the ciphertext over a valid/ready handshake. It is the sequencer that sits above the round-level datapath blocks.

---
 rtl/aes_pkg.sv | 94 +++++++++
 rtl/aes_key_expand_step.sv | 27 ++
 rtl/aes128_round_ctrl.sv | 98 +++++++++
 tb/tb_aes128_round_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM state type and GF(2^8) helpers.
//   Byte order is FIPS-197: byte i of a 128-bit block sits at [127-8*i -: 8],
//   column-major (byte 4*c+r is row r of column c).
//   Round transforms (sub_bytes, shift_rows, mix_columns) are pure functions
//   so the controller and key expansion share one S-box definition.
package aes_pkg;

    localparam int NB = 4;
    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Out-of-range indices return 0 so the lookup is safe in every FSM state.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) v = RCON[idx];
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (b^254, with 0 -> 0) followed
    // by the FIPS-197 affine transform, so no 256-entry table has to be typed.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// aes_key_expand_step: one AES-128 key-schedule step (combinational).
//   key_in  [127:0]  previous round key, words w0..w3 from MSB
//   rcon    [7:0]    round constant for the key being produced
//   key_out [127:0]  next round key
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = key_in;

    // RotWord, SubWord, Rcon on the last word, then the XOR chain.
    assign w_t  = sub_word({w_w3[23:0], w_w3[31:24]}) ^ {rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign key_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: iterative AES-128 encryptor, one round per clock.
//   clk, rst_n               clock / async active-low reset
//   in_valid/in_ready        plaintext+key handshake (in_ready = IDLE)
//   in_data, in_key [127:0]  sampled only on the accept edge
//   out_valid/out_ready      ciphertext handshake, out_data held until taken
//   busy                     high in ROUND or DONE
//   round_idx, round_key     debug view of the round counter / key register
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx,
    output logic [127:0] round_key
);

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_out;
    logic [3:0]   r_idx;
    logic         r_out_valid;

    logic [127:0] w_nk;
    logic [127:0] w_sr;
    logic [127:0] w_rnd;
    logic         w_last;

    aes_key_expand_step u_kexp (
        .key_in  (r_key),
        .rcon    (rcon_of(r_idx)),
        .key_out (w_nk)
    );

    // Final round bypasses mix_columns.
    assign w_last = (r_idx == 4'(NUM_ROUNDS));
    assign w_sr   = shift_rows(sub_bytes(r_state));
    assign w_rnd  = (w_last ? w_sr : mix_columns(w_sr)) ^ w_nk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_out       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data ^ in_key;
                        r_key   <= in_key;
                        r_idx   <= 4'd1;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_key <= w_nk;
                    if (w_last) begin
                        r_out       <= w_rnd;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_state <= w_rnd;
                        r_idx   <= r_idx + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idx       <= '0;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign busy      = (r_fsm != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign round_idx = r_idx;
    assign round_key = r_key;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
module tb_aes128_round_ctrl;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ST1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data, round_key;
    logic [3:0]   round_idx;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [127:0] sb_q [$];

    always #5 clk = ~clk;

    aes128_round_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx),
        .round_key (round_key)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard sink: a handshake completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected_out", 128'(sb_q.size()), 128'd1);
            else chk("out_data", out_data, sb_q.pop_front());
        end
    end

    // Returns #1 after the accept edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, input bit push);
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = pt; in_key = key;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("accept_tmo", 128'(in_ready), 128'd1);
        @(posedge clk);
        if (push) sb_q.push_back(exp);
        #1 in_valid = 1'b0;
    endtask

    // Counts posedges from the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        if (!out_valid) chk("out_tmo", 128'(out_valid), 128'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_busy"},      128'(busy),      128'd0);
        chk({tag, "_round_idx"}, 128'(round_idx), 128'd0);
        chk({tag, "_out_data"},  out_data,        128'd0);
        chk({tag, "_round_key"}, round_key,       128'd0);
        chk({tag, "_state"},     dut.r_state,     128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [127:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // App. B with latency and intermediate key/state checks
        out_ready = 1'b1;
        send(PT_B, KEY_B, CT_B, 1'b1);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (lat == 1) begin
                chk("e1_round_key", round_key, RK1_B);
                chk("e1_state", dut.r_state, ST1_B);
                chk("e1_round_idx", 128'(round_idx), 128'd2);
                chk("e1_busy", 128'(busy), 128'd1);
            end
        end while (!out_valid && lat < 40);
        chk("b_latency", 128'(lat), 128'd10);
        chk("e10_round_key", round_key, RK10_B);
        @(negedge clk);
        chk("b_idle_in_ready", 128'(in_ready), 128'd1);
        chk("b_idle_idx", 128'(round_idx), 128'd0);

        // App. C.1 with 5 cycles of backpressure
        out_ready = 1'b0;
        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_out(lat);
        chk("c_latency", 128'(lat), 128'd10);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_data", out_data, held);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_post_valid", 128'(out_valid), 128'd0);
        chk("bp_post_ready", 128'(in_ready), 128'd1);

        // in_valid held with churning in_data during ROUND
        send(PT_B, KEY_B, CT_B, 1'b1);
        in_valid = 1'b1;
        lat = 0;
        do begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); lat++;
            @(negedge clk);
            if (!out_valid) chk("ign_in_ready", 128'(in_ready), 128'd0);
            #1;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        chk("ign_latency", 128'(lat), 128'd10);
        @(negedge clk);
        chk("ign_no_second_accept", 128'(busy), 128'd0);

        // reset in the middle of round 5
        out_ready = 1'b1;
        send(PT_C, KEY_C, CT_C, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("mid_round_idx", 128'(round_idx), 128'd5);
        rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 128'(out_valid), 128'd0);
            if (i == 3) rst_n = 1'b1;
        end
        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_out(lat);
        chk("c2_latency", 128'(lat), 128'd10);

        repeat (3) @(negedge clk);
        chk("sb_drain", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
